lime_control_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit Lime processor. Moore FSM: decodes IR opcode, sequences the

---
 rtl/lime_pkg.sv | 92 +++++++++
 rtl/lime_ctrl_outdec.sv | 106 ++++++++++
 rtl/lime_control_fsm.sv | 112 +++++++++++
 tb/tb_lime_control_fsm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lime_pkg.sv
// Shared constants and control-word type for the Lime multi-cycle control unit.
package lime_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 4;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_LUI  = 4'h8;
  localparam logic [3:0] OP_IN   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // State encodings; 4'hF is never entered
  localparam logic [3:0] S_FETCH    = 4'h0;
  localparam logic [3:0] S_DECODE   = 4'h1;
  localparam logic [3:0] S_EXEC_R   = 4'h2;
  localparam logic [3:0] S_WB_ALU   = 4'h3;
  localparam logic [3:0] S_EXEC_I   = 4'h4;
  localparam logic [3:0] S_WB_I     = 4'h5;
  localparam logic [3:0] S_MEM_ADDR = 4'h6;
  localparam logic [3:0] S_MEM_RD   = 4'h7;
  localparam logic [3:0] S_WB_MEM   = 4'h8;
  localparam logic [3:0] S_MEM_WR   = 4'h9;
  localparam logic [3:0] S_BRANCH   = 4'hA;
  localparam logic [3:0] S_JUMP     = 4'hB;
  localparam logic [3:0] S_WB_IN    = 4'hC;
  localparam logic [3:0] S_OUT_ST   = 4'hD;
  localparam logic [3:0] S_HALT     = 4'hE;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_LUI   = 3'd3;

  // Writeback source select
  localparam logic [1:0] WBS_ALUOUT = 2'd0;
  localparam logic [1:0] WBS_MDR    = 2'd1;
  localparam logic [1:0] WBS_PC     = 2'd2;
  localparam logic [1:0] WBS_IN     = 2'd3;

  // Register destination select
  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R15 = 2'd2;

  // ALU operand selects
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_A      = 1'b1;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_TWO    = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       out_write;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

  // Opcodes B..E have no defined instruction
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/lime_ctrl_outdec.sv
// Moore output decoder: state (plus opcode/zero where needed) to datapath control word.
module lime_ctrl_outdec
  import lime_pkg::*;
#(
  parameter int unsigned HALT_ILL = 0
) (
  input  logic [ST_W-1:0] i_state,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_zero,
  input  logic            i_mem_ready,
  input  logic            i_en,
  output ctrl_t           o_ctrl
);

  ctrl_t w_ctrl;

  // Decode control word; forced to zero while reset is held
  always_comb begin
    w_ctrl = '0;
    if (i_en) begin
      case (i_state)
        S_FETCH: begin
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.ir_write  = i_mem_ready;
          w_ctrl.pc_write  = i_mem_ready;
          w_ctrl.alu_src_a = SRCA_PC;
          w_ctrl.alu_src_b = SRCB_TWO;
          w_ctrl.alu_op    = ALU_ADD;
          w_ctrl.pc_source = PCS_ALU;
        end
        S_DECODE: begin
          w_ctrl.alu_src_a  = SRCA_PC;
          w_ctrl.alu_src_b  = SRCB_IMM_SH;
          w_ctrl.alu_op     = ALU_ADD;
          w_ctrl.illegal_op = is_illegal(i_opcode) && (HALT_ILL == 0);
        end
        S_EXEC_R: begin
          w_ctrl.alu_src_a = SRCA_A;
          w_ctrl.alu_src_b = SRCB_B;
          w_ctrl.alu_op    = ALU_FUNCT;
        end
        S_WB_ALU: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = RD_RD;
          w_ctrl.wb_src    = WBS_ALUOUT;
        end
        S_EXEC_I: begin
          w_ctrl.alu_src_a = SRCA_A;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.alu_op    = (i_opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
        end
        S_WB_I: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = RD_RT;
          w_ctrl.wb_src    = WBS_ALUOUT;
        end
        S_MEM_ADDR: begin
          w_ctrl.alu_src_a = SRCA_A;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = RD_RT;
          w_ctrl.wb_src    = WBS_MDR;
        end
        S_MEM_WR: begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          w_ctrl.alu_src_a     = SRCA_A;
          w_ctrl.alu_src_b     = SRCB_B;
          w_ctrl.alu_op        = ALU_SUB;
          w_ctrl.pc_source     = PCS_ALUOUT;
          w_ctrl.pc_write_cond = ((i_opcode == OP_BEQ) &&  i_zero) ||
                                 ((i_opcode == OP_BNE) && !i_zero);
        end
        S_JUMP: begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.pc_source = PCS_JUMP;
          if (i_opcode == OP_JAL) begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.reg_dst   = RD_R15;
            w_ctrl.wb_src    = WBS_PC;
          end
        end
        S_WB_IN: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = RD_RT;
          w_ctrl.wb_src    = WBS_IN;
        end
        S_OUT_ST: w_ctrl.out_write = 1'b1;
        S_HALT:   w_ctrl.halted    = 1'b1;
        default:  w_ctrl = '0;
      endcase
    end
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/lime_control_fsm.sv
// Multi-cycle control FSM for the Lime processor: next-state sequencing here,
// control word decoded in lime_ctrl_outdec.
// Optional build macro LIME_MEM_WAIT_EN adds mem_ready and stalls memory states.
module lime_control_fsm
  import lime_pkg::*;
#(
  parameter int unsigned OPW      = OP_W,
  parameter int unsigned STW      = ST_W,
  parameter int unsigned HALT_ILL = 0
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
`ifdef LIME_MEM_WAIT_EN
  input  logic           mem_ready,
`endif
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           ir_write,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic [1:0]     reg_dst,
  output logic [1:0]     wb_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           out_write,
  output logic           halted,
  output logic           illegal_op
);

  logic [STW-1:0]  r_state;
  logic [STW-1:0]  w_next;
  logic [OP_W-1:0] w_op;
  logic            w_mem_ready;
  ctrl_t           w_ctrl;

  assign w_op = OP_W'(opcode);

`ifdef LIME_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= STW'(S_FETCH);
    else        r_state <= w_next;
  end

  // Next-state sequencing; unknown encodings recover to FETCH
  always_comb begin
    w_next = STW'(S_FETCH);
    case (ST_W'(r_state))
      S_FETCH:  w_next = w_mem_ready ? STW'(S_DECODE) : STW'(S_FETCH);
      S_DECODE: begin
        case (w_op)
          OP_R:            w_next = STW'(S_EXEC_R);
          OP_ADDI, OP_LUI: w_next = STW'(S_EXEC_I);
          OP_LW, OP_SW:    w_next = STW'(S_MEM_ADDR);
          OP_BEQ, OP_BNE:  w_next = STW'(S_BRANCH);
          OP_J, OP_JAL:    w_next = STW'(S_JUMP);
          OP_IN:           w_next = STW'(S_WB_IN);
          OP_OUT:          w_next = STW'(S_OUT_ST);
          OP_HALT:         w_next = STW'(S_HALT);
          default:         w_next = (HALT_ILL != 0) ? STW'(S_HALT) : STW'(S_FETCH);
        endcase
      end
      S_EXEC_R:   w_next = STW'(S_WB_ALU);
      S_EXEC_I:   w_next = STW'(S_WB_I);
      S_MEM_ADDR: w_next = (w_op == OP_LW) ? STW'(S_MEM_RD) : STW'(S_MEM_WR);
      S_MEM_RD:   w_next = w_mem_ready ? STW'(S_WB_MEM) : STW'(S_MEM_RD);
      S_MEM_WR:   w_next = w_mem_ready ? STW'(S_FETCH) : STW'(S_MEM_WR);
      S_HALT:     w_next = STW'(S_HALT);
      default:    w_next = STW'(S_FETCH);
    endcase
  end

  lime_ctrl_outdec #(
    .HALT_ILL (HALT_ILL)
  ) u_outdec (
    .i_state     (ST_W'(r_state)),
    .i_opcode    (w_op),
    .i_zero      (zero),
    .i_mem_ready (w_mem_ready),
    .i_en        (RST_N),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign ir_write      = w_ctrl.ir_write;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign reg_write     = w_ctrl.reg_write;
  assign reg_dst       = w_ctrl.reg_dst;
  assign wb_src        = w_ctrl.wb_src;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign out_write     = w_ctrl.out_write;
  assign halted        = w_ctrl.halted;
  assign illegal_op    = w_ctrl.illegal_op;

endmodule

// File: tb/tb_lime_control_fsm.sv
// Self-checking bench for lime_control_fsm: instruction-level reference model
// plus directed literal checks; a second instance covers HALT_ILL=1.
module tb_lime_control_fsm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] opcode, opcode1;
  logic       zero;

  always #5 CLK = ~CLK;

  // Instance 0 (HALT_ILL=0)
  logic pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, wb_src, alu_src_b, pc_source;
  logic alu_src_a, out_write, halted, illegal_op;
  logic [2:0] alu_op;

  // Instance 1 (HALT_ILL=1)
  logic pw1, pwc1, irw1, iod1, mr1, mw1, rw1, sa1, ow1, h1, il1;
  logic [1:0] dst1, wb1, sb1, ps1;
  logic [2:0] aop1;

`ifdef LIME_MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif

  lime_control_fsm #(.HALT_ILL(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .zero(zero),
`ifdef LIME_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .out_write(out_write), .halted(halted),
    .illegal_op(illegal_op)
  );

  lime_control_fsm #(.HALT_ILL(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode1), .zero(1'b0),
`ifdef LIME_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pw1), .pc_write_cond(pwc1), .ir_write(irw1),
    .i_or_d(iod1), .mem_read(mr1), .mem_write(mw1),
    .reg_write(rw1), .reg_dst(dst1), .wb_src(wb1),
    .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(aop1),
    .pc_source(ps1), .out_write(ow1), .halted(h1),
    .illegal_op(il1)
  );

  logic [21:0] act, act1;
  assign act  = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                 reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_op,
                 pc_source, out_write, halted, illegal_op};
  assign act1 = {pw1, pwc1, irw1, iod1, mr1, mw1, rw1, dst1, wb1, sa1, sb1,
                 aop1, ps1, ow1, h1, il1};

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: position within the current instruction
  int m_step = 0;
  bit m_halt = 1'b0;

  // Number of cycles an instruction takes, from FETCH back to FETCH
  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h3, 4'h8:               return 4;
      4'h2:                                 return 5;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA:   return 3;
      default:                              return 2;
    endcase
  endfunction

  // Expected control word for a given instruction and cycle within it
  function automatic logic [21:0] expect_word(input logic [3:0] op, input int step,
                                              input bit halt, input logic z);
    logic pw, pwc, irw, iod, mr, mw, rw, sa, ow, h, ill;
    logic [1:0] dst, wb, sb, ps;
    logic [2:0] aop;
    {pw, pwc, irw, iod, mr, mw, rw, sa, ow, h, ill} = '0;
    dst = 0; wb = 0; sb = 0; ps = 0; aop = 0;
    if (halt) h = 1'b1;
    else if (step == 0) begin
      mr = 1; irw = 1; pw = 1; sb = 2'd1;
    end else if (step == 1) begin
      sb = 2'd3; ill = (op >= 4'hB) && (op <= 4'hE);
    end else if (step == 2) begin
      case (op)
        4'h0: begin sa = 1; sb = 2'd0; aop = 3'd2; end
        4'h1, 4'h2, 4'h3: begin sa = 1; sb = 2'd2; end
        4'h8: begin sa = 1; sb = 2'd2; aop = 3'd3; end
        4'h4: begin sa = 1; aop = 3'd1; ps = 2'd1; pwc = z; end
        4'h5: begin sa = 1; aop = 3'd1; ps = 2'd1; pwc = ~z; end
        4'h6: begin pw = 1; ps = 2'd2; end
        4'h7: begin pw = 1; ps = 2'd2; rw = 1; dst = 2'd2; wb = 2'd2; end
        4'h9: begin rw = 1; wb = 2'd3; end
        4'hA: ow = 1;
        default: ;
      endcase
    end else if (step == 3) begin
      case (op)
        4'h0: begin rw = 1; dst = 2'd1; end
        4'h1, 4'h8: rw = 1;
        4'h2: begin mr = 1; iod = 1; end
        4'h3: begin mw = 1; iod = 1; end
        default: ;
      endcase
    end else if (step == 4 && op == 4'h2) begin
      rw = 1; wb = 2'd1;
    end
    return {pw, pwc, irw, iod, mr, mw, rw, dst, wb, sa, sb, aop, ps, ow, h, ill};
  endfunction

  // Advance the model at each active edge using the inputs present before it
  always @(posedge CLK) begin
    if (!RST_N) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 1 && opcode == 4'hF) m_halt = 1'b1;
      else if (m_step + 1 >= instr_len(opcode)) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  // Every-cycle comparison of instance 0 against the model
  always @(negedge CLK) begin
    logic [21:0] exp_w;
    if (cmp_en) begin
      exp_w = RST_N ? expect_word(opcode, m_step, m_halt, zero) : 22'h0;
      checks++;
      if (act !== exp_w) begin
        errors++;
        $display("FAIL ctrl_word t=%0t op=%h step=%0d act=%h exp=%h",
                 $time, opcode, m_step, act, exp_w);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Run a branch from FETCH and check the conditional PC load in its third cycle
  task automatic branch_chk(input logic [3:0] op, input logic z, input logic taken);
    opcode = op;
    zero   = z;
    @(negedge CLK);
    chk("br_fetch", 32'(ir_write), 32'd1);
    tick();
    tick();
    @(negedge CLK);
    chk("br_cond", 32'(pc_write_cond), 32'(taken));
    chk("br_pcsrc", 32'(pc_source), 32'd1);
    tick();
  endtask

  initial begin
    int mr_cnt, rw_cnt;
    logic [1:0] wb_seen;
    RST_N   = 1'b0;
    opcode  = 4'h2;
    opcode1 = 4'h2;
    zero    = 1'b0;
    cmp_en  = 1'b1;

    // Reset held two cycles with LW opcode present
    repeat (2) begin
      @(negedge CLK);
      chk("reset_zero", 32'(act), 32'd0);
      chk("reset_zero_inst1", 32'(act1), 32'd0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // LW: 5 cycles, two memory reads, one MDR writeback
    mr_cnt = 0; rw_cnt = 0; wb_seen = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 0) chk("fetch_after_reset", 32'({mem_read, ir_write, pc_write}), 32'h7);
      mr_cnt += int'(mem_read);
      if (reg_write) begin
        rw_cnt++;
        wb_seen = wb_src;
      end
      tick();
    end
    chk("lw_mem_read_count", 32'(mr_cnt), 32'd2);
    chk("lw_reg_write_count", 32'(rw_cnt), 32'd1);
    chk("lw_wb_src", 32'(wb_seen), 32'd1);

    branch_chk(4'h4, 1'b1, 1'b1);
    branch_chk(4'h4, 1'b0, 1'b0);
    branch_chk(4'h5, 1'b0, 1'b1);
    branch_chk(4'h5, 1'b1, 1'b0);

    // Illegal opcode with HALT_ILL=0: one-cycle pulse, then FETCH
    opcode = 4'hC;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    tick();
    @(negedge CLK);
    chk("ill_next_fetch", 32'({illegal_op, ir_write}), 32'h1);

    // Random instruction stream with occasional mid-instruction resets
    for (int c = 0; c < 2000; c++) begin
      tick();
      zero  = 1'($urandom_range(0, 1));
      RST_N = ($urandom_range(0, 59) != 0);
      if (m_step == 0) opcode = 4'($urandom_range(0, 14));
    end

    // HALT opcode: absorbing
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 10 && m_step != 0; i++) tick();
    opcode = 4'hF;
    repeat (25) tick();
    @(negedge CLK);
    chk("halt_stays", 32'(halted), 32'd1);

    // Instance 1: illegal opcode enters HALT and stays there
    tick();
    RST_N   = 1'b0;
    opcode1 = 4'hC;
    tick();
    RST_N = 1'b1;
    tick();
    @(negedge CLK);
    chk("ill1_decode", 32'({h1, il1}), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("ill1_halt_hold", 32'(act1), 32'h2);
      tick();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
